// File: rtl/wash_led_seq.sv
// Programme sequencer that produces the LED command buses for the panel LED driver.
// Ports: clk, rst (sync, active-high); tick (timing enable), start (one-cycle request),
//   pause (level, freezes timing), sel_drw[2:0] (stage selection);
//   ld_drw/fl_drw/ld_fsd[2:0] (steady / flashing stage LEDs, phase LEDs), busy, done (pulse).
// Bit mapping: drw [2]=dry [1]=rinse [0]=wash; fsd [2]=fill [1]=spin [0]=drain.
// Optional end-of-programme flash state enabled by defining WASH_LED_SEQ_DONE_FLASH_EN.
module wash_led_seq #(
  parameter int T_FILL  = 3,
  parameter int T_WASH  = 6,
  parameter int T_RINSE = 4,
  parameter int T_DRAIN = 2,
  parameter int T_DRY   = 5,
  parameter int T_DONE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] sel_drw,
  output logic [2:0] ld_drw,
  output logic [2:0] fl_drw,
  output logic [2:0] ld_fsd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_AGIT_W,
    S_AGIT_R,
    S_DRAIN,
    S_SPIN
`ifdef WASH_LED_SEQ_DONE_FLASH_EN
    , S_DONE
`endif
  } state_t;

  localparam logic [7:0] L_FILL  = 8'(T_FILL);
  localparam logic [7:0] L_WASH  = 8'(T_WASH);
  localparam logic [7:0] L_RINSE = 8'(T_RINSE);
  localparam logic [7:0] L_DRAIN = 8'(T_DRAIN);
  localparam logic [7:0] L_DRY   = 8'(T_DRY);
`ifdef WASH_LED_SEQ_DONE_FLASH_EN
  localparam logic [7:0] L_DONE  = 8'(T_DONE);
  localparam state_t     S_END   = S_DONE;
`else
  localparam state_t     S_END   = S_IDLE;
`endif

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, cnt_inc, lim;
  logic [2:0] pend, pend_n, act, act_n;
  logic [2:0] ld_drw_n, fl_drw_n, ld_fsd_n;
  logic       busy_n, done_n, acc;

  // The active stage is always the lowest pending bit: a stage's pend bit is
  // only cleared when that stage finishes, and stages run in bit order.
  function automatic logic [2:0] lowest(input logic [2:0] p);
    if (p[0])      return 3'b001;
    else if (p[1]) return 3'b010;
    else if (p[2]) return 3'b100;
    else           return 3'b000;
  endfunction

  // First phase of the next pending stage, or the end state if none remain.
  function automatic state_t stage_entry(input logic [2:0] p);
    if (p[0] | p[1]) return S_FILL;
    else if (p[2])   return S_SPIN;
    else             return S_END;
  endfunction

  assign acc     = tick & ~pause;
  assign cnt_inc = cnt + 8'd1;
  assign act     = lowest(pend);

  always_comb begin
    lim = L_FILL;
    case (state)
      S_FILL:   lim = L_FILL;
      S_AGIT_W: lim = L_WASH;
      S_AGIT_R: lim = L_RINSE;
      S_DRAIN:  lim = L_DRAIN;
      S_SPIN:   lim = L_DRY;
`ifdef WASH_LED_SEQ_DONE_FLASH_EN
      S_DONE:   lim = L_DONE;
`endif
      default:  lim = L_FILL;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    if (state == S_IDLE) begin
      if (start && (sel_drw != 3'b000)) begin
        pend_n  = sel_drw;
        state_n = stage_entry(sel_drw);
        cnt_n   = 8'd0;
      end
    end else if (acc) begin
      if (cnt_inc == lim) begin
        cnt_n = 8'd0;
        case (state)
          S_FILL:   state_n = act[0] ? S_AGIT_W : S_AGIT_R;
          S_AGIT_W,
          S_AGIT_R: state_n = S_DRAIN;
          S_DRAIN,
          S_SPIN: begin
            pend_n  = pend & ~act;
            state_n = stage_entry(pend & ~act);
          end
          default:  state_n = S_IDLE;
        endcase
      end else begin
        cnt_n = cnt_inc;
      end
    end
  end

  // Output decode from the next-state values, so the registered outputs
  // change on the same edge as the state register.
  always_comb begin
    act_n    = lowest(pend_n);
    fl_drw_n = 3'b000;
    ld_drw_n = 3'b000;
    ld_fsd_n = 3'b000;
    busy_n   = (state_n != S_IDLE);
    done_n   = (state != S_IDLE) && (state_n == S_IDLE);
    case (state_n)
      S_IDLE: ;
`ifdef WASH_LED_SEQ_DONE_FLASH_EN
      S_DONE: fl_drw_n = 3'b111;
`endif
      default: begin
        fl_drw_n = act_n;
        ld_drw_n = pend_n & ~act_n;
        case (state_n)
          S_FILL:  ld_fsd_n = 3'b100;
          S_SPIN:  ld_fsd_n = 3'b010;
          S_DRAIN: ld_fsd_n = 3'b001;
          default: ld_fsd_n = 3'b000;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      pend   <= 3'b000;
      ld_drw <= 3'b000;
      fl_drw <= 3'b000;
      ld_fsd <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pend   <= pend_n;
      ld_drw <= ld_drw_n;
      fl_drw <= fl_drw_n;
      ld_fsd <= ld_fsd_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_wash_led_seq.sv
module tb_wash_led_seq;

  localparam int T_FILL  = 3;
  localparam int T_WASH  = 6;
  localparam int T_RINSE = 4;
  localparam int T_DRAIN = 2;
  localparam int T_DRY   = 5;
  localparam int T_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] sel_drw = 3'b000;
  logic [2:0] ld_drw, fl_drw, ld_fsd;
  logic       busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] fl;
    logic [2:0] ld;
    logic [2:0] fsd;
    int         ticks;
  } seg_t;

  seg_t sb[$];

  wash_led_seq #(
    .T_FILL(T_FILL), .T_WASH(T_WASH), .T_RINSE(T_RINSE),
    .T_DRAIN(T_DRAIN), .T_DRY(T_DRY), .T_DONE(T_DONE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .sel_drw(sel_drw), .ld_drw(ld_drw), .fl_drw(fl_drw), .ld_fsd(ld_fsd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {busy, fl_drw, ld_drw, ld_fsd, done}
  function automatic logic [10:0] obs();
    return {busy, fl_drw, ld_drw, ld_fsd, done};
  endfunction

  // Expected phase segments for a programme, derived from the selection.
  task automatic push_prog(input logic [2:0] sel);
    logic [2:0] rem;
    rem = sel;
    if (sel[0]) begin
      rem[0] = 1'b0;
      sb.push_back('{3'b001, rem, 3'b100, T_FILL});
      sb.push_back('{3'b001, rem, 3'b000, T_WASH});
      sb.push_back('{3'b001, rem, 3'b001, T_DRAIN});
    end
    if (sel[1]) begin
      rem[1] = 1'b0;
      sb.push_back('{3'b010, rem, 3'b100, T_FILL});
      sb.push_back('{3'b010, rem, 3'b000, T_RINSE});
      sb.push_back('{3'b010, rem, 3'b001, T_DRAIN});
    end
    if (sel[2]) begin
      rem[2] = 1'b0;
      sb.push_back('{3'b100, rem, 3'b010, T_DRY});
    end
`ifdef WASH_LED_SEQ_DONE_FLASH_EN
    sb.push_back('{3'b111, 3'b000, 3'b000, T_DONE});
`endif
  endtask

  task automatic pulse_start(input logic [2:0] sel);
    @(negedge clk);
    sel_drw = sel;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Two quiet cycles then a one-cycle tick; returns at the negedge after it.
  task automatic do_tick();
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // mode 0: plain run; 1: start with sel 010 while busy; 2: pause 10 ticks in segment 1 after 2 ticks
  task automatic run_segments(input int mode, input string name);
    seg_t        e;
    logic [10:0] exp;
    int          segi;
    segi = 0;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      exp = {1'b1, e.fl, e.ld, e.fsd, 1'b0};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("FAIL %s seg_entry[%0d] got=%b exp=%b", name, segi, obs(), exp);
      end
      for (int k = 1; k <= e.ticks; k++) begin
        if (mode == 1 && segi == 0 && k == 2) begin
          pulse_start(3'b010);
          total++;
          if (obs() !== exp) begin
            bad++;
            $display("FAIL %s start_while_busy got=%b exp=%b", name, obs(), exp);
          end
        end
        if (mode == 2 && segi == 1 && k == 3) begin
          @(negedge clk);
          pause = 1'b1;
          for (int p = 0; p < 10; p++) begin
            do_tick();
            total++;
            if (obs() !== exp) begin
              bad++;
              $display("FAIL %s pause_hold[%0d] got=%b exp=%b", name, p, obs(), exp);
            end
          end
          pause = 1'b0;
        end
        do_tick();
        if (k < e.ticks) begin
          total++;
          if (obs() !== exp) begin
            bad++;
            $display("FAIL %s seg_hold[%0d] tick %0d got=%b exp=%b", name, segi, k, obs(), exp);
          end
        end
      end
      segi++;
    end
    total++;
    if (obs() !== 11'b0_000_000_000_1) begin
      bad++;
      $display("FAIL %s done_pulse got=%b exp=%b", name, obs(), 11'b0_000_000_000_1);
    end
    @(negedge clk);
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL %s done_clear got=%b exp=%b", name, obs(), 11'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", obs(), 11'b0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL reset_no_done got=%b exp=%b", obs(), 11'b0);
    end
  endtask

  task automatic test_full();
    push_prog(3'b111);
    pulse_start(3'b111);
    run_segments(0, "full_111");
  endtask

  task automatic test_skip_rinse();
    push_prog(3'b101);
    pulse_start(3'b101);
    run_segments(0, "skip_101");
  endtask

  task automatic test_ignore_zero();
    pulse_start(3'b000);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      total++;
      if (obs() !== 11'b0) begin
        bad++;
        $display("FAIL ignore_zero_sel[%0d] got=%b exp=%b", i, obs(), 11'b0);
      end
    end
  endtask

  task automatic test_start_busy();
    push_prog(3'b001);
    pulse_start(3'b001);
    run_segments(1, "start_busy");
  endtask

  task automatic test_pause();
    push_prog(3'b001);
    pulse_start(3'b001);
    run_segments(2, "pause");
  endtask

  task automatic test_reset_mid();
    pulse_start(3'b010);
    do_tick();
    total++;
    if (obs() !== 11'b1_010_000_100_0) begin
      bad++;
      $display("FAIL rst_mid_pre got=%b exp=%b", obs(), 11'b1_010_000_100_0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL rst_mid_clear got=%b exp=%b", obs(), 11'b0);
    end
    @(negedge clk);
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL rst_mid_no_done got=%b exp=%b", obs(), 11'b0);
    end
    push_prog(3'b010);
    pulse_start(3'b010);
    run_segments(0, "after_rst_010");
  endtask

  task automatic test_dry_only();
    push_prog(3'b100);
    pulse_start(3'b100);
    run_segments(0, "dry_100");
  endtask

  initial begin
    test_reset();
    test_full();
    test_skip_rinse();
    test_ignore_zero();
    test_start_busy();
    test_pause();
    test_reset_mid();
    test_dry_only();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
